// File: rtl/skill_manager_if.sv
// Signal bundle between the keyboard/stage logic and skill_manager.
// The master drives key levels and the stage flag; the slave (skill_manager) returns skill state.
interface skill_manager_if;
    logic       enable;
    logic       key_j;
    logic       key_k;
    logic       key_l;
    logic [2:0] skill;
    logic [2:0] skill_remain;
    logic [1:0] skill_point;
    logic [2:0] point_bar;

    modport master (
        output enable, key_j, key_k, key_l,
        input  skill, skill_remain, skill_point, point_bar
    );

    modport slave (
        input  enable, key_j, key_k, key_l,
        output skill, skill_remain, skill_point, point_bar
    );
endinterface

// File: rtl/skill_manager.sv
// Skill activation, duration timers and regenerating point pool for the J/K/L skills.
// Optional macro SKILL_REFRESH_EN: a press on an active skill reloads its timer for one point.
module skill_manager #(
    parameter int REGEN_TICKS = 200,
    parameter int MAX_POINTS  = 3,
    parameter int DUR_J       = 100,
    parameter int DUR_K       = 100,
    parameter int DUR_L       = 100
) (
    input logic            clk,
    input logic            rst,
    skill_manager_if.slave bus
);
    localparam logic [15:0] REGEN_LAST = 16'(REGEN_TICKS - 1);
    localparam logic [1:0]  MAX_PT     = 2'(MAX_POINTS);

    logic [2:0]  key_now;
    logic [2:0]  prev_key;
    logic [2:0]  rise;
    logic [2:0]  avail;
    logic [2:0]  eligible;
    logic [2:0]  grant;
    logic        spend;
    logic        regen_wrap;
    logic [15:0] regen_cnt;
    logic [15:0] regen_nxt;
    logic [1:0]  point_nxt;
    logic [2:0]  bar_nxt;
    logic [2:0]  remain_nxt;
    logic [15:0] timer     [3];
    logic [15:0] timer_nxt [3];

    function automatic logic [15:0] dur_of(input int idx);
        case (idx)
            0:       dur_of = 16'(DUR_J);
            1:       dur_of = 16'(DUR_K);
            default: dur_of = 16'(DUR_L);
        endcase
    endfunction

    assign key_now = {bus.key_l, bus.key_k, bus.key_j};
    assign rise    = key_now & ~prev_key;

`ifdef SKILL_REFRESH_EN
    assign avail = 3'b111;
`else
    assign avail = ~bus.skill_remain;
`endif

    assign eligible = (bus.enable && bus.skill_point != 2'd0) ? (rise & avail) : 3'b000;

    // Only one acceptance per tick; lower-priority rises are dropped for good.
    always_comb begin
        grant = 3'b000;
        if (eligible[0])      grant = 3'b001;
        else if (eligible[1]) grant = 3'b010;
        else if (eligible[2]) grant = 3'b100;
    end

    assign spend      = |grant;
    assign regen_wrap = bus.enable && (regen_cnt == REGEN_LAST);

    always_comb begin
        if (!bus.enable || regen_wrap) regen_nxt = 16'd0;
        else                           regen_nxt = regen_cnt + 16'd1;
    end

    // A spend and a regen on the same tick cancel out.
    always_comb begin
        point_nxt = bus.skill_point;
        if (spend && !regen_wrap)
            point_nxt = bus.skill_point - 2'd1;
        else if (regen_wrap && !spend && bus.skill_point < MAX_PT)
            point_nxt = bus.skill_point + 2'd1;
    end

    always_comb begin
        case (point_nxt)
            2'd0:    bar_nxt = 3'b000;
            2'd1:    bar_nxt = 3'b100;
            2'd2:    bar_nxt = 3'b110;
            default: bar_nxt = 3'b111;
        endcase
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            timer_nxt[i] = 16'd0;
            if (!bus.enable)
                timer_nxt[i] = 16'd0;
            else if (grant[i])
                timer_nxt[i] = dur_of(i);
            else if (timer[i] != 16'd0)
                timer_nxt[i] = timer[i] - 16'd1;
            remain_nxt[i] = (timer_nxt[i] != 16'd0);
        end
    end

    // NOTE: prev_key samples regardless of enable, so a key already held when play starts never fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_key         <= 3'b000;
            regen_cnt        <= 16'd0;
            bus.skill        <= 3'b000;
            bus.skill_remain <= 3'b000;
            bus.skill_point  <= 2'd0;
            bus.point_bar    <= 3'b000;
            for (int i = 0; i < 3; i++) timer[i] <= 16'd0;
        end else begin
            prev_key         <= key_now;
            regen_cnt        <= regen_nxt;
            bus.skill        <= grant;
            bus.skill_remain <= remain_nxt;
            bus.skill_point  <= point_nxt;
            bus.point_bar    <= bar_nxt;
            for (int i = 0; i < 3; i++) timer[i] <= timer_nxt[i];
        end
    end
endmodule
